// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the hazard/forwarding controller
// Purpose: EX operand forwarding select encoding used by the controller and
//          by the EX-stage operand muxes.
// Ports:   none (package).
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_DM   = 2'b01,
    FWD_WB   = 2'b10,
    FWD_RSV  = 2'b11
  } fwd_sel_e;

endpackage

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - pending-write scoreboard for long-latency units
// Purpose: one pending bit per architectural register, outstanding-op count
//          and a sticky error for inconsistent completions.
// Ports:   clk/rst (async active-high), set_en/set_rd (issue),
//          clr_en/clr_rd (completion), q_rs1/q_rs2/q_rd query addresses with
//          matching *_pend results, full, pend_cnt, sb_err.
module reg_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int MAX_PEND = 4,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int PC_W = $clog2(MAX_PEND + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            set_en,
  input  logic [RA_W-1:0] set_rd,
  input  logic            clr_en,
  input  logic [RA_W-1:0] clr_rd,
  input  logic [RA_W-1:0] q_rs1,
  input  logic [RA_W-1:0] q_rs2,
  input  logic [RA_W-1:0] q_rd,
  output logic            q_rs1_pend,
  output logic            q_rs2_pend,
  output logic            q_rd_pend,
  output logic            full,
  output logic [PC_W-1:0] pend_cnt,
  output logic            sb_err
);

  localparam logic [PC_W-1:0] MAX_C = PC_W'(MAX_PEND);

  logic [NUM_REGS-1:0] pend_q, pend_nxt;
  logic [PC_W-1:0]     cnt_q, cnt_nxt;
  logic                err_q, err_evt;
  logic                set_v, clr_v, clr_ok;

  // x0 is never tracked, so its bit stays clear and it never queries pending
  assign set_v  = set_en & (set_rd != '0);
  assign clr_v  = clr_en & (clr_rd != '0);
  assign clr_ok = clr_v & pend_q[clr_rd];

  always_comb begin
    pend_nxt = pend_q;
    cnt_nxt  = cnt_q;
    err_evt  = clr_v & ~pend_q[clr_rd];
    // clear before set so an issue and completion to the same register
    // leaves the bit set (the new op is still outstanding)
    if (clr_ok) pend_nxt[clr_rd] = 1'b0;
    if (set_v)  pend_nxt[set_rd] = 1'b1;
    if (set_v && !clr_ok) begin
      if (cnt_q == MAX_C) err_evt = 1'b1;
      else                cnt_nxt = cnt_q + PC_W'(1);
    end else if (!set_v && clr_ok) begin
      cnt_nxt = cnt_q - PC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      pend_q <= pend_nxt;
      cnt_q  <= cnt_nxt;
      if (err_evt) err_q <= 1'b1;
    end
  end

  assign q_rs1_pend = pend_q[q_rs1];
  assign q_rs2_pend = pend_q[q_rs2];
  assign q_rd_pend  = pend_q[q_rd];
  assign full       = (cnt_q == MAX_C);
  assign pend_cnt   = cnt_q;
  assign sb_err     = err_q;

endmodule

// File: rtl/hazard_forward_sb.sv
// rtl/hazard_forward_sb.sv - 5-stage pipeline hazard, forwarding and scoreboard control
// Purpose: detects RAW hazards against EX/DM and long-latency ops, drives
//          PC/IF-ID/ID-EX stall and clear, EX operand forwarding selects and
//          a saturating stall-cycle counter.
// Ports:   i_clk, i_reset (async active-high); ID fields (rs1/rs2/rd, used,
//          reg_wr, is_long, branch/jalr/taken); EX/DM/WB dest and write
//          enables; long issue/done; outputs o_stall_pc_if, o_stall_if_id,
//          o_clear_if_id, o_clear_id_ex, o_rs1_sel, o_rs2_sel, o_pend_cnt,
//          o_sb_err, o_stall_cnt.
module hazard_forward_sb
  import hazard_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int FWD_EN      = 1,
  parameter int MAX_PEND    = 4,
  parameter int STALL_CNT_W = 16,
  localparam int RA_W = $clog2(NUM_REGS),
  localparam int PC_W = $clog2(MAX_PEND + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [RA_W-1:0]        i_rs1_addr_id,
  input  logic [RA_W-1:0]        i_rs2_addr_id,
  input  logic [RA_W-1:0]        i_rd_addr_id,
  input  logic                   i_rs1_used_id,
  input  logic                   i_rs2_used_id,
  input  logic                   i_reg_wr_id,
  input  logic                   i_is_long_id,
  input  logic                   i_opcode_is_branch,
  input  logic                   i_opcode_is_jalr,
  input  logic                   i_branch_taken,
  input  logic [RA_W-1:0]        i_rs1_addr_ex,
  input  logic [RA_W-1:0]        i_rs2_addr_ex,
  input  logic [RA_W-1:0]        i_rd_addr_ex,
  input  logic [RA_W-1:0]        i_rd_addr_dm,
  input  logic [RA_W-1:0]        i_rd_addr_wb,
  input  logic                   i_reg_wr_ex,
  input  logic                   i_reg_wr_dm,
  input  logic                   i_reg_wr_wb,
  input  logic                   i_is_load_ex,
  input  logic                   i_long_issue_ex,
  input  logic                   i_long_done,
  input  logic [RA_W-1:0]        i_long_done_rd,
  output logic                   o_stall_pc_if,
  output logic                   o_stall_if_id,
  output logic                   o_clear_if_id,
  output logic                   o_clear_id_ex,
  output fwd_sel_e               o_rs1_sel,
  output fwd_sel_e               o_rs2_sel,
  output logic [PC_W-1:0]        o_pend_cnt,
  output logic                   o_sb_err,
  output logic [STALL_CNT_W-1:0] o_stall_cnt
);

  logic rs1_v, rs2_v, rd_v;
  logic raw_ex, raw_dm;
  logic pipe_stall, br_stall, issue_hit, sb_stall, stall;
  logic q_rs1_pend, q_rs2_pend, q_rd_pend, sb_full;
  logic [STALL_CNT_W-1:0] stall_cnt_q;

  function automatic fwd_sel_e fwd_pick(input logic [RA_W-1:0] src);
    if (src == '0)                               return FWD_NONE;
    else if (i_reg_wr_dm && src == i_rd_addr_dm) return FWD_DM;
    else if (i_reg_wr_wb && src == i_rd_addr_wb) return FWD_WB;
    else                                         return FWD_NONE;
  endfunction

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .MAX_PEND (MAX_PEND)
  ) u_sb (
    .clk        (i_clk),
    .rst        (i_reset),
    .set_en     (i_long_issue_ex),
    .set_rd     (i_rd_addr_ex),
    .clr_en     (i_long_done),
    .clr_rd     (i_long_done_rd),
    .q_rs1      (i_rs1_addr_id),
    .q_rs2      (i_rs2_addr_id),
    .q_rd       (i_rd_addr_id),
    .q_rs1_pend (q_rs1_pend),
    .q_rs2_pend (q_rs2_pend),
    .q_rd_pend  (q_rd_pend),
    .full       (sb_full),
    .pend_cnt   (o_pend_cnt),
    .sb_err     (o_sb_err)
  );

  // only real, non-x0 operands of the ID instruction can hazard
  assign rs1_v = i_rs1_used_id & (i_rs1_addr_id != '0);
  assign rs2_v = i_rs2_used_id & (i_rs2_addr_id != '0);
  assign rd_v  = i_reg_wr_id   & (i_rd_addr_id  != '0);

  assign raw_ex = i_reg_wr_ex & ((rs1_v & (i_rs1_addr_id == i_rd_addr_ex)) |
                                 (rs2_v & (i_rs2_addr_id == i_rd_addr_ex)));
  assign raw_dm = i_reg_wr_dm & ((rs1_v & (i_rs1_addr_id == i_rd_addr_dm)) |
                                 (rs2_v & (i_rs2_addr_id == i_rd_addr_dm)));

  assign pipe_stall = (FWD_EN != 0) ? (raw_ex & i_is_load_ex) : (raw_ex | raw_dm);

  // branches resolve in ID, so EX/DM results cannot be forwarded to them
  assign br_stall = (i_opcode_is_branch | i_opcode_is_jalr) & (raw_ex | raw_dm);

  // the pending bit for an op issuing this cycle is not yet visible
  assign issue_hit = i_long_issue_ex & (i_rd_addr_ex != '0) &
                     ((rs1_v & (i_rs1_addr_id == i_rd_addr_ex)) |
                      (rs2_v & (i_rs2_addr_id == i_rd_addr_ex)) |
                      (rd_v  & (i_rd_addr_id  == i_rd_addr_ex)));

  assign sb_stall = (rs1_v & q_rs1_pend) | (rs2_v & q_rs2_pend) | (rd_v & q_rd_pend) |
                    issue_hit | (i_is_long_id & sb_full);

  assign stall = ~i_reset & (pipe_stall | br_stall | sb_stall);

  assign o_stall_pc_if = stall;
  assign o_stall_if_id = stall;
  assign o_clear_id_ex = stall;
  // a stalled branch is re-evaluated next cycle, so no redirect flush yet
  assign o_clear_if_id = ~i_reset & i_branch_taken & ~stall;

  assign o_rs1_sel = (i_reset || FWD_EN == 0) ? FWD_NONE : fwd_pick(i_rs1_addr_ex);
  assign o_rs2_sel = (i_reset || FWD_EN == 0) ? FWD_NONE : fwd_pick(i_rs2_addr_ex);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                            stall_cnt_q <= '0;
    else if (stall && stall_cnt_q != '1)    stall_cnt_q <= stall_cnt_q + STALL_CNT_W'(1);
  end

  assign o_stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_forward_sb.sv
// tb/tb_hazard_forward_sb.sv - scoreboard bench for hazard_forward_sb
module tb_hazard_forward_sb;
  import hazard_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, rd_dm, rd_wb, done_rd;
  logic       rs1_used, rs2_used, wr_id, long_id, is_br, is_jalr, taken;
  logic       wr_ex, wr_dm, wr_wb, load_ex, issue, done;

  logic        stall_pc[3], stall_ifid[3], clr_ifid[3], clr_idex[3], err[3];
  logic [1:0]  s1[3], s2[3];
  logic [15:0] scnt[3];
  logic [2:0]  pend_a, pend_b;
  logic [1:0]  pend_c;

  hazard_forward_sb #(.FWD_EN(1), .MAX_PEND(4)) dut_a (
    .i_clk(clk), .i_reset(rst),
    .i_rs1_addr_id(rs1_id), .i_rs2_addr_id(rs2_id), .i_rd_addr_id(rd_id),
    .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used), .i_reg_wr_id(wr_id),
    .i_is_long_id(long_id), .i_opcode_is_branch(is_br), .i_opcode_is_jalr(is_jalr),
    .i_branch_taken(taken), .i_rs1_addr_ex(rs1_ex), .i_rs2_addr_ex(rs2_ex),
    .i_rd_addr_ex(rd_ex), .i_rd_addr_dm(rd_dm), .i_rd_addr_wb(rd_wb),
    .i_reg_wr_ex(wr_ex), .i_reg_wr_dm(wr_dm), .i_reg_wr_wb(wr_wb),
    .i_is_load_ex(load_ex), .i_long_issue_ex(issue), .i_long_done(done),
    .i_long_done_rd(done_rd),
    .o_stall_pc_if(stall_pc[0]), .o_stall_if_id(stall_ifid[0]),
    .o_clear_if_id(clr_ifid[0]), .o_clear_id_ex(clr_idex[0]),
    .o_rs1_sel(s1[0]), .o_rs2_sel(s2[0]), .o_pend_cnt(pend_a),
    .o_sb_err(err[0]), .o_stall_cnt(scnt[0]));

  hazard_forward_sb #(.FWD_EN(0), .MAX_PEND(4)) dut_b (
    .i_clk(clk), .i_reset(rst),
    .i_rs1_addr_id(rs1_id), .i_rs2_addr_id(rs2_id), .i_rd_addr_id(rd_id),
    .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used), .i_reg_wr_id(wr_id),
    .i_is_long_id(long_id), .i_opcode_is_branch(is_br), .i_opcode_is_jalr(is_jalr),
    .i_branch_taken(taken), .i_rs1_addr_ex(rs1_ex), .i_rs2_addr_ex(rs2_ex),
    .i_rd_addr_ex(rd_ex), .i_rd_addr_dm(rd_dm), .i_rd_addr_wb(rd_wb),
    .i_reg_wr_ex(wr_ex), .i_reg_wr_dm(wr_dm), .i_reg_wr_wb(wr_wb),
    .i_is_load_ex(load_ex), .i_long_issue_ex(issue), .i_long_done(done),
    .i_long_done_rd(done_rd),
    .o_stall_pc_if(stall_pc[1]), .o_stall_if_id(stall_ifid[1]),
    .o_clear_if_id(clr_ifid[1]), .o_clear_id_ex(clr_idex[1]),
    .o_rs1_sel(s1[1]), .o_rs2_sel(s2[1]), .o_pend_cnt(pend_b),
    .o_sb_err(err[1]), .o_stall_cnt(scnt[1]));

  hazard_forward_sb #(.FWD_EN(1), .MAX_PEND(2)) dut_c (
    .i_clk(clk), .i_reset(rst),
    .i_rs1_addr_id(rs1_id), .i_rs2_addr_id(rs2_id), .i_rd_addr_id(rd_id),
    .i_rs1_used_id(rs1_used), .i_rs2_used_id(rs2_used), .i_reg_wr_id(wr_id),
    .i_is_long_id(long_id), .i_opcode_is_branch(is_br), .i_opcode_is_jalr(is_jalr),
    .i_branch_taken(taken), .i_rs1_addr_ex(rs1_ex), .i_rs2_addr_ex(rs2_ex),
    .i_rd_addr_ex(rd_ex), .i_rd_addr_dm(rd_dm), .i_rd_addr_wb(rd_wb),
    .i_reg_wr_ex(wr_ex), .i_reg_wr_dm(wr_dm), .i_reg_wr_wb(wr_wb),
    .i_is_load_ex(load_ex), .i_long_issue_ex(issue), .i_long_done(done),
    .i_long_done_rd(done_rd),
    .o_stall_pc_if(stall_pc[2]), .o_stall_if_id(stall_ifid[2]),
    .o_clear_if_id(clr_ifid[2]), .o_clear_id_ex(clr_idex[2]),
    .o_rs1_sel(s1[2]), .o_rs2_sel(s2[2]), .o_pend_cnt(pend_c),
    .o_sb_err(err[2]), .o_stall_cnt(scnt[2]));

  typedef struct {
    string nm;
    int    d;
    int    stall;
    int    clr;
    int    sel1;
    int    sel2;
    int    pend;
    int    err;
    int    scnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   n_chk  = 0;
  int   n_fail = 0;
  int   act_pend;

  task automatic cmp(input string nm, input string f, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%0d required=%0d", nm, f, act, req);
    end
  endtask

  // monitor: pops one expectation per cycle presented and compares
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      act_pend = (e.d == 0) ? int'(pend_a) : (e.d == 1) ? int'(pend_b) : int'(pend_c);
      cmp(e.nm, "stall_pc_if", int'(stall_pc[e.d]), e.stall);
      cmp(e.nm, "stall_if_id", int'(stall_ifid[e.d]), e.stall);
      cmp(e.nm, "clear_id_ex", int'(clr_idex[e.d]), e.stall);
      cmp(e.nm, "clear_if_id", int'(clr_ifid[e.d]), e.clr);
      cmp(e.nm, "rs1_sel", int'(s1[e.d]), e.sel1);
      cmp(e.nm, "rs2_sel", int'(s2[e.d]), e.sel2);
      cmp(e.nm, "pend_cnt", act_pend, e.pend);
      cmp(e.nm, "sb_err", int'(err[e.d]), e.err);
      cmp(e.nm, "stall_cnt", int'(scnt[e.d]), e.scnt);
    end
  end

  task automatic idle();
    rs1_id = 0; rs2_id = 0; rd_id = 0; rs1_ex = 0; rs2_ex = 0; rd_ex = 0;
    rd_dm = 0; rd_wb = 0; done_rd = 0;
    rs1_used = 0; rs2_used = 0; wr_id = 0; long_id = 0; is_br = 0; is_jalr = 0;
    taken = 0; wr_ex = 0; wr_dm = 0; wr_wb = 0; load_ex = 0; issue = 0; done = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int d, input int st, input int cl,
                     input int a1, input int a2, input int pd, input int er, input int sc);
    exp_t x;
    x.nm = nm; x.d = d; x.stall = st; x.clr = cl; x.sel1 = a1; x.sel2 = a2;
    x.pend = pd; x.err = er; x.scnt = sc;
    q.push_back(x);
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    tick();

    // reset holds outputs low even with hazarding inputs
    rs1_id = 5; rs1_used = 1; rd_ex = 5; wr_ex = 1; load_ex = 1;
    rs1_ex = 5; rd_dm = 5; wr_dm = 1;
    chk("rst_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    // forwarding, FWD_EN=1
    idle(); rs1_ex = 5; rs2_ex = 3; rd_dm = 5; wr_dm = 1;
    chk("fwd_dm", 0, 0, 0, 1, 0, 0, 0, 0);
    idle(); rs1_ex = 5; rs2_ex = 7; rd_dm = 5; wr_dm = 1; rd_wb = 5; wr_wb = 1;
    chk("fwd_dm_prio", 0, 0, 0, 1, 0, 0, 0, 0);
    idle(); rs1_ex = 7; rs2_ex = 7; rd_dm = 5; wr_dm = 1; rd_wb = 7; wr_wb = 1;
    chk("fwd_wb", 0, 0, 0, 2, 2, 0, 0, 0);
    idle(); rs1_ex = 0; rd_dm = 0; wr_dm = 1; rs2_ex = 9; rd_wb = 9; wr_wb = 1;
    chk("fwd_x0", 0, 0, 0, 0, 2, 0, 0, 0);
    idle(); rs2_ex = 4; rd_dm = 4; wr_dm = 0; rd_wb = 4; wr_wb = 1;
    chk("fwd_dm_nowr", 0, 0, 0, 0, 2, 0, 0, 0);

    // load-use: one stall then DM forward
    idle(); rs1_id = 6; rs1_used = 1; rd_ex = 6; wr_ex = 1; load_ex = 1;
    chk("ld_use_stall", 0, 1, 0, 0, 0, 0, 0, 0);
    idle(); rs1_ex = 6; rd_dm = 6; wr_dm = 1;
    chk("ld_use_fwd", 0, 0, 0, 1, 0, 0, 0, 1);
    idle(); rs2_id = 4; rs2_used = 1; rd_ex = 4; wr_ex = 1;
    chk("alu_raw_ex", 0, 0, 0, 0, 0, 0, 0, 1);

    // branch depending on ALU op: EX then DM stall, release from WB
    idle(); is_br = 1; rs1_id = 4; rs1_used = 1; rd_ex = 4; wr_ex = 1;
    chk("br_ex", 0, 1, 0, 0, 0, 0, 0, 1);
    idle(); is_br = 1; rs1_id = 4; rs1_used = 1; rd_dm = 4; wr_dm = 1; taken = 1;
    chk("br_dm_taken", 0, 1, 0, 0, 0, 0, 0, 2);
    idle(); is_br = 1; rs1_id = 4; rs1_used = 1; rd_wb = 4; wr_wb = 1; taken = 1;
    chk("br_release", 0, 0, 1, 0, 0, 0, 0, 3);

    // DIV x8 issued, done 10 cycles later
    idle(); issue = 1; rd_ex = 8; rs1_id = 8; rs1_used = 1;
    chk("div_issue", 0, 1, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 9; i++) begin
      idle(); rs1_id = 8; rs1_used = 1;
      chk("div_wait", 0, 1, 0, 0, 0, 1, 0, 4 + i);
    end
    idle(); rs1_id = 8; rs1_used = 1; done = 1; done_rd = 8;
    chk("div_done", 0, 1, 0, 0, 0, 1, 0, 13);
    idle(); rs1_id = 8; rs1_used = 1;
    chk("div_release", 0, 0, 0, 0, 0, 0, 0, 14);

    // spurious done, sticky error, async reset mid long op
    idle(); done = 1; done_rd = 9;
    chk("err_done", 0, 0, 0, 0, 0, 0, 0, 14);
    idle(); issue = 1; rd_ex = 11;
    chk("err_sticky", 0, 0, 0, 0, 0, 0, 1, 14);
    idle();
    chk("pend_one", 0, 0, 0, 0, 0, 1, 1, 14);
    idle(); rs1_id = 11; rs1_used = 1; rst = 1'b1;
    chk("async_rst", 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle(); rs1_id = 11; rs1_used = 1;
    chk("post_rst", 0, 0, 0, 0, 0, 0, 0, 0);

    // FWD_EN=0: two stall cycles, selects stay 00
    do_reset();
    idle(); rs1_id = 7; rs1_used = 1; rd_ex = 7; wr_ex = 1; rs1_ex = 3; rd_dm = 3; wr_dm = 1;
    chk("nofwd_ex", 1, 1, 0, 0, 0, 0, 0, 0);
    idle(); rs1_id = 7; rs1_used = 1; rd_dm = 7; wr_dm = 1;
    chk("nofwd_dm", 1, 1, 0, 0, 0, 0, 0, 1);
    idle(); rs1_id = 7; rs1_used = 1; rs1_ex = 7; rd_wb = 7; wr_wb = 1;
    chk("nofwd_wb", 1, 0, 0, 0, 0, 0, 0, 2);

    // MAX_PEND=2
    do_reset();
    idle(); issue = 1; rd_ex = 12;
    chk("mp_issue1", 2, 0, 0, 0, 0, 0, 0, 0);
    idle(); issue = 1; rd_ex = 13;
    chk("mp_issue2", 2, 0, 0, 0, 0, 1, 0, 0);
    idle(); long_id = 1; wr_id = 1; rd_id = 14;
    chk("mp_full", 2, 1, 0, 0, 0, 2, 0, 0);
    idle(); long_id = 1; wr_id = 1; rd_id = 14; done = 1; done_rd = 12;
    chk("mp_full_done", 2, 1, 0, 0, 0, 2, 0, 1);
    idle(); long_id = 1; wr_id = 1; rd_id = 14; issue = 1; rd_ex = 15; done = 1; done_rd = 13;
    chk("mp_iss_done", 2, 0, 0, 0, 0, 1, 0, 2);
    idle(); issue = 1; rd_ex = 15; done = 1; done_rd = 15;
    chk("mp_same_reg", 2, 0, 0, 0, 0, 1, 0, 2);
    idle(); rs1_id = 15; rs1_used = 1;
    chk("mp_set_wins", 2, 1, 0, 0, 0, 1, 0, 2);

    idle();
    tick();
    tick();
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain actual=%0d required=0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
